// File: rtl/pattern_gen_1011.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first, reps times,
// with an optional idle gap between repetitions, then pulses done for one cycle.
module pattern_gen_1011 #(
    parameter int              PAT_W   = 4,
    parameter int              CNT_W   = 8,
    parameter int              GAP_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q,   state_d;
    logic [PAT_W-1:0] shift_q,   shift_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [CNT_W-1:0] reps_q,    reps_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        pat_d     = pat_q;
        reps_d    = reps_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d     = use_def ? DEF_PAT : pattern;
                    shift_d   = use_def ? DEF_PAT : pattern;
                    reps_d    = reps;
                    gap_d     = gap;
                    bit_cnt_d = LAST_BIT;
                    state_d   = (reps != '0) ? S_SEND : S_DONE;
                end
            end

            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    shift_d = '0;
                end else if (bit_cnt_q == '0) begin
                    // Last bit of this repetition is on the line now.
                    reps_d = reps_q - CNT_W'(1);
                    if (reps_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        shift_d = '0;
                    end else if (gap_q == '0) begin
                        shift_d   = pat_q;
                        bit_cnt_d = LAST_BIT;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q - GAP_W'(1);
                    end
                end else begin
                    shift_d   = {shift_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    shift_d = '0;
                end else if (gap_cnt_q == '0) begin
                    state_d   = S_SEND;
                    shift_d   = pat_q;
                    bit_cnt_d = LAST_BIT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
        if (!rstn) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decode purely from registered state.
    assign ready     = (state_q == S_IDLE);
    assign out_valid = (state_q == S_SEND);
    assign out       = (state_q == S_SEND) & shift_q[PAT_W-1];
    assign busy      = (state_q == S_SEND) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_gen_1011.sv
// Scoreboarded bench for pattern_gen_1011: a request model predicts the bit stream and
// busy/done timing; a monitor pops expected bits whenever out_valid is high.
module tb_pattern_gen_1011;

    localparam int               PAT_W = 4;
    localparam int               CNT_W = 8;
    localparam int               GAP_W = 4;
    localparam logic [PAT_W-1:0] DEF   = 4'b1011;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic             use_def;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    int pass_n  = 0;
    int total_n = 0;
    logic sb[$];

    pattern_gen_1011 #(
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W),
        .DEF_PAT(DEF)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .use_def  (use_def),
        .pattern  (pattern),
        .reps     (reps),
        .gap      (gap),
        .abort    (abort),
        .ready    (ready),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every valid bit on the line must be the next bit the model predicted.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) check("unexpected_bit", 1, 0);
            else check("stream_bit", int'(out), int'(sb.pop_front()));
        end
        if (busy === 1'b1 && out_valid === 1'b0) check("gap_out_zero", int'(out), 0);
    end

    // Reference: the line during busy cycles is reps copies of the pattern, MSB first,
    // separated by gap idle cycles. Entries are {valid, bit}.
    function automatic void model_stream(input logic [PAT_W-1:0] p, input int r, input int g,
                                         output logic [1:0] s[$]);
        s = {};
        for (int k = 0; k < r; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) s.push_back({1'b1, p[b]});
            if (k < r - 1) for (int z = 0; z < g; z++) s.push_back(2'b00);
        end
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_start", int'(ready === 1'b1), 1);
    endtask

    task automatic run_req(input bit ud, input logic [PAT_W-1:0] p, input int r, input int g,
                           input int abort_at, input bit start_mid);
        logic [1:0] s[$];
        logic [PAT_W-1:0] eff;
        int exp_busy, n_cyc, cyc, busy_n, done_n, done_cyc, first_busy, ready_cyc;
        wait_ready();
        eff = ud ? DEF : p;
        model_stream(eff, r, g, s);
        exp_busy = s.size();
        n_cyc = (abort_at >= 0) ? abort_at + 1 : exp_busy;
        for (int i = 0; i < n_cyc; i++) if (s[i][1]) sb.push_back(s[i][0]);

        start = 1'b1; use_def = ud; pattern = p; reps = CNT_W'(r); gap = GAP_W'(g);
        @(negedge clk);
        start = 1'b0;
        use_def = 1'($urandom); pattern = PAT_W'($urandom);
        reps = CNT_W'($urandom); gap = GAP_W'($urandom);

        cyc = 0; busy_n = 0; done_n = 0; done_cyc = -1; first_busy = -1; ready_cyc = -1;
        while (cyc < 3000) begin
            if (busy === 1'b1) begin
                if (first_busy < 0) first_busy = cyc;
                busy_n++;
            end
            if (done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
            if (ready === 1'b1) begin
                ready_cyc = cyc;
                break;
            end
            abort = (abort_at >= 0 && busy === 1'b1 && busy_n == abort_at + 1);
            start = (start_mid && busy === 1'b1 && busy_n == 2);
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;

        check("ready_returned", int'(ready_cyc >= 0), 1);
        if (abort_at >= 0) begin
            check("abort_busy_cycles", busy_n, abort_at + 1);
            check("abort_no_done", done_n, 0);
            check("abort_ready_cycle", ready_cyc, abort_at + 1);
            check("abort_out_valid", int'(out_valid), 0);
        end else begin
            check("busy_cycles", busy_n, exp_busy);
            check("done_count", done_n, 1);
            check("done_cycle", done_cyc, exp_busy);
            check("ready_cycle", ready_cyc, exp_busy + 1);
            check("first_busy", first_busy, (r > 0) ? 0 : -1);
        end
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; use_def = 1'b0; pattern = '0;
        reps = '0; gap = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        rstn = 1'b1;
        @(negedge clk);

        run_req(1'b1, 4'b0000, 1, 0, -1, 1'b0);   // default single shot
        run_req(1'b0, 4'b1101, 3, 0, -1, 1'b0);   // back-to-back repetitions
        run_req(1'b1, 4'b0000, 2, 3, -1, 1'b0);   // gap insertion
        run_req(1'b0, 4'b0110, 0, 5, -1, 1'b0);   // zero reps
        run_req(1'b0, 4'b1001, 2, 1, -1, 1'b1);   // start mid-SEND ignored
        run_req(1'b0, 4'b1110, 2, 2, 1, 1'b0);    // abort in 2nd bit of rep 1
        run_req(1'b0, 4'b0101, 1, 0, -1, 1'b0);   // accepted normally after abort
        run_req(1'b1, 4'b0000, 2, 2, 9, 1'b0);    // abort on the last bit's edge
        run_req(1'b0, 4'b1100, 3, 2, 5, 1'b0);    // abort during GAP
        run_req(1'b0, 4'b0011, 255, 0, -1, 1'b0); // max reps
        run_req(1'b0, 4'b1010, 2, 15, -1, 1'b0);  // max gap

        // Reset during GAP: bits 0..3 were sent, cycles 4..5 are gap.
        wait_ready();
        for (int b = PAT_W - 1; b >= 0; b--) sb.push_back(DEF[b]);
        start = 1'b1; use_def = 1'b1; reps = 8'd2; gap = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_in_gap", int'(busy && !out_valid), 1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_ready", int'(ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("postrst_no_done", int'(done), 0);
        check("postrst_sb_drained", sb.size(), 0);

        for (int t = 0; t < 25; t++) begin
            int r, g, ab;
            r  = $urandom_range(0, 4);
            g  = $urandom_range(0, 3);
            ab = -1;
            if (r > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(0, r * PAT_W + (r - 1) * g - 1);
            run_req(1'($urandom), PAT_W'($urandom), r, g, ab, 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/pattern_gen_1011.md
Name: pattern_gen_1011

Overview:
Serial pattern transmitter; drives a single-bit stream carrying a programmable PAT_W-bit pattern (default 1011), MSB first, one bit per clock. Produces stimulus for the serial sequence detectors in the same design. It can also be used in loopback as the line source. A request handshake loads the pattern, a repetition count and an inter-repetition gap. The block then serialises autonomously and pulses done at the end.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of repetition count
GAP_W, 4, width of idle-gap length (cycles of 0 between repetitions)
DEF_PAT, 4'b1011, pattern used when use_def=1 (width PAT_W)

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  synchronous reset, active low
start  in  1  request; accepted when start && ready
use_def  in  1  1: send DEF_PAT, 0: send pattern input (sampled on accept)
pattern  in  PAT_W  pattern to send, sampled on accept
reps  in  CNT_W  number of repetitions, sampled on accept
gap  in  GAP_W  idle cycles between repetitions, sampled on accept
abort  in  1  synchronous cancel of an active transfer
ready  out  1  high only in IDLE
out  out  1  serial data bit
out_valid  out  1  high on every cycle a pattern bit is on out
busy  out  1  high in SEND or GAP
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rstn).
- Reset: the first posedge with rstn=0 sets state=IDLE, shift register=0, counters=0, out=0, out_valid=0, busy=0, done=0, ready=1. Reset overrides start and abort. Reset during a transfer drops it with no done.
- Registers: all outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - ready=1.
  - On start=1 at a posedge: latch the pattern (DEF_PAT if use_def=1), reps and gap; set the bit counter to PAT_W-1.
  - If reps!=0, go to SEND. If reps==0, go to DONE (no bits sent).
  - start while not in IDLE is ignored; no queueing.
- SEND:
  - out = shift-reg MSB, out_valid=1, busy=1. Shift left one bit per cycle.
  - Latency: accept at edge N; first bit is visible in cycle N..N+1 (after edge N); last bit follows PAT_W-1 cycles later.
- End of each repetition (after the last bit):
  - Decrement the remaining repetition count.
  - If the remaining count is 0, go to DONE.
  - Else if gap==0, reload the pattern and continue SEND back-to-back, with no bubble.
  - Else go to GAP.
- GAP:
  - out=0, out_valid=0, busy=1 for exactly gap cycles.
  - Then reload the pattern and return to SEND.
- DONE: done=1 and ready=0 for one cycle, then IDLE. The earliest next accept is the cycle after done.
- abort:
  - In SEND or GAP, the next edge goes to IDLE with out=0, out_valid=0 and no done pulse.
  - abort in IDLE or DONE is ignored; DONE still pulses.
  - abort takes priority over end-of-repetition transitions on the same edge.
- Counters:
  - The repetition counter is CNT_W wide; max reps = 2^CNT_W-1, with no wrap.
  - The gap counter is GAP_W wide; max gap = 2^GAP_W-1.
  - The bit counter is clog2(PAT_W) wide and wraps to PAT_W-1 on reload.
- Total cycles for one request: busy cycles = reps*PAT_W + (reps-1)*gap. done follows the last busy cycle.
- Input stability: inputs other than start and abort may change freely after accept; they are not re-sampled.

Test Plan:
- Default single shot: use_def=1, reps=1, gap=0, start pulse at edge N -> out=1,0,1,1 with out_valid=1 in the 4 cycles after N; done=1 in the 5th cycle; ready=1 in the 6th.
- Back-to-back repetitions: pattern=4'b1101, use_def=0, reps=3, gap=0 -> 12 consecutive valid bits 110111011101, busy high 12 cycles, a single done pulse.
- Gap insertion: DEF_PAT, reps=2, gap=3 -> 1011, then 3 cycles of out=0/out_valid=0, then 1011, then done; busy high for 11 cycles.
- Zero reps and ignored start: reps=0 -> no out_valid, done pulses the cycle after accept. Start asserted mid-SEND -> no effect on the stream or on counts.
- Abort: reps=2, gap=2, abort during the 2nd bit of repetition 1 -> out_valid=0 and ready=1 after the next edge, no done; a new start is accepted normally.
- Reset mid-transfer: rstn=0 for one edge during GAP -> all outputs at reset values next cycle, no done. Also check abort and end-of-last-bit on the same edge -> IDLE, no done.
